pre_if_stage: RTL and testbench

- Upstream neighbour of the IF stage. Owns the fetch PC and issues instruction fetches over an SRAM-like split handshake (req/addr_ok/data_ok).
- Hands {pc, instruction} pairs to IF through a valid/allow_in handshake.
- Applies exception, eret and branch redirects, and cancels wrong-path fetches that are still in flight.

---
 rtl/pre_if_stage.sv | 115 +++++++++++
 tb/tb_pre_if_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, issues one SRAM-style fetch at a time and
// hands {pc, instruction} pairs to IF, applying exception/eret/branch redirects.
module pre_if_stage #(
    parameter logic [31:0] RESET_PC        = 32'hbfc00000,
    parameter logic [31:0] EXCEPTION_ENTRY = 32'hbfc00380
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_allow_in,
    output logic        to_if_valid,
    output logic [31:0] to_if_program_count,
    output logic [31:0] to_if_instruction,
    input  logic        id_branch_taken,
    input  logic [31:0] id_branch_target,
    input  logic        wb_exception_valid,
    input  logic        wb_eret_flush,
    input  logic [31:0] cp0_epc,
    output logic        instruction_ram_request,
    output logic [31:0] instruction_ram_address,
    input  logic        instruction_ram_address_ok,
    input  logic        instruction_ram_data_ok,
    input  logic [31:0] instruction_ram_read_data
);

    localparam logic [1:0] REQ  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic        cancel;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        misaligned;

    always_comb begin
        redirect        = wb_exception_valid | wb_eret_flush | id_branch_taken;
        redirect_target = id_branch_target;
        if (wb_exception_valid)
            redirect_target = EXCEPTION_ENTRY;
        else if (wb_eret_flush)
            redirect_target = cp0_epc;
    end

    assign misaligned = (fetch_pc[1:0] != 2'b00);

    // A misaligned PC never reaches memory; IF sees it as a pair with a zero word.
    assign instruction_ram_request = reset && (state == REQ) && !misaligned;
    assign instruction_ram_address = fetch_pc;

    assign to_if_valid         = reset && (state == HOLD) && !redirect;
    assign to_if_program_count = hold_pc;
    assign to_if_instruction   = hold_inst;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= REQ;
            fetch_pc  <= RESET_PC;
            cancel    <= 1'b0;
            hold_pc   <= 32'd0;
            hold_inst <= 32'd0;
        end else begin
            case (state)
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= redirect_target;
                        // An accepted request is already wrong-path: drop its response.
                        if (instruction_ram_request && instruction_ram_address_ok) begin
                            cancel <= 1'b1;
                            state  <= WAIT;
                        end
                    end else if (misaligned) begin
                        hold_pc   <= fetch_pc;
                        hold_inst <= 32'd0;
                        state     <= HOLD;
                    end else if (instruction_ram_address_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (instruction_ram_data_ok) begin
                        cancel <= 1'b0;
                        if (redirect) begin
                            fetch_pc <= redirect_target;
                            state    <= REQ;
                        end else if (cancel) begin
                            state <= REQ;
                        end else begin
                            hold_pc   <= fetch_pc;
                            hold_inst <= instruction_ram_read_data;
                            state     <= HOLD;
                        end
                    end else if (redirect) begin
                        cancel   <= 1'b1;
                        fetch_pc <= redirect_target;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        fetch_pc <= redirect_target;
                        state    <= REQ;
                    end else if (if_allow_in) begin
                        fetch_pc <= hold_pc + 32'd4;
                        state    <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed-vector bench for pre_if_stage; the bench plays the instruction SRAM.
module tb_pre_if_stage;

    logic        clock;
    logic        reset;
    logic        if_allow_in;
    logic        to_if_valid;
    logic [31:0] to_if_program_count;
    logic [31:0] to_if_instruction;
    logic        id_branch_taken;
    logic [31:0] id_branch_target;
    logic        wb_exception_valid;
    logic        wb_eret_flush;
    logic [31:0] cp0_epc;
    logic        instruction_ram_request;
    logic [31:0] instruction_ram_address;
    logic        instruction_ram_address_ok;
    logic        instruction_ram_data_ok;
    logic [31:0] instruction_ram_read_data;

    int nvec = 0;
    int nerr = 0;

    pre_if_stage dut (
        .clock                      (clock),
        .reset                      (reset),
        .if_allow_in                (if_allow_in),
        .to_if_valid                (to_if_valid),
        .to_if_program_count        (to_if_program_count),
        .to_if_instruction          (to_if_instruction),
        .id_branch_taken            (id_branch_taken),
        .id_branch_target           (id_branch_target),
        .wb_exception_valid         (wb_exception_valid),
        .wb_eret_flush              (wb_eret_flush),
        .cp0_epc                    (cp0_epc),
        .instruction_ram_request    (instruction_ram_request),
        .instruction_ram_address    (instruction_ram_address),
        .instruction_ram_address_ok (instruction_ram_address_ok),
        .instruction_ram_data_ok    (instruction_ram_data_ok),
        .instruction_ram_read_data  (instruction_ram_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // One complete fetch from REQ, with memory answering addr_ok and data_ok at once.
    // Leaves the DUT in HOLD with the pair checked.
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] d);
        #1;
        chk({tag, "_req"}, 32'(instruction_ram_request), 32'd1);
        chk({tag, "_addr"}, instruction_ram_address, a);
        instruction_ram_address_ok = 1'b1;
        tick();
        instruction_ram_address_ok = 1'b0;
        instruction_ram_data_ok    = 1'b1;
        instruction_ram_read_data  = d;
        #1;
        chk({tag, "_wait_req"}, 32'(instruction_ram_request), 32'd0);
        chk({tag, "_wait_vld"}, 32'(to_if_valid), 32'd0);
        tick();
        instruction_ram_data_ok = 1'b0;
        #1;
        chk({tag, "_vld"}, 32'(to_if_valid), 32'd1);
        chk({tag, "_pc"}, to_if_program_count, a);
        chk({tag, "_inst"}, to_if_instruction, d);
    endtask

    // Accept the held pair and check the follow-on request address.
    task automatic transfer(input string tag, input logic [31:0] next_a);
        if_allow_in = 1'b1;
        tick();
        if_allow_in = 1'b0;
        #1;
        chk({tag, "_next_req"}, 32'(instruction_ram_request), 32'd1);
        chk({tag, "_next_addr"}, instruction_ram_address, next_a);
    endtask

    initial begin
        reset                      = 1'b0;
        if_allow_in                = 1'b0;
        id_branch_taken            = 1'b0;
        id_branch_target           = 32'd0;
        wb_exception_valid         = 1'b0;
        wb_eret_flush              = 1'b0;
        cp0_epc                    = 32'd0;
        instruction_ram_address_ok = 1'b0;
        instruction_ram_data_ok    = 1'b0;
        instruction_ram_read_data  = 32'd0;

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("rst_req", 32'(instruction_ram_request), 32'd0);
            chk("rst_vld", 32'(to_if_valid), 32'd0);
            chk("rst_pc", to_if_program_count, 32'd0);
        end
        reset = 1'b1;

        fetch("first", 32'hbfc00000, 32'h11111111);
        transfer("first", 32'hbfc00004);

        // backpressure: pair stays put, no new request
        fetch("bp", 32'hbfc00004, 32'h22222222);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk("bp_vld", 32'(to_if_valid), 32'd1);
            chk("bp_pc", to_if_program_count, 32'hbfc00004);
            chk("bp_inst", to_if_instruction, 32'h22222222);
            chk("bp_req", 32'(instruction_ram_request), 32'd0);
        end
        transfer("bp", 32'hbfc00008);

        fetch("seq8", 32'hbfc00008, 32'h33333333);
        transfer("seq8", 32'hbfc0000c);
        fetch("seqc", 32'hbfc0000c, 32'h44444444);
        transfer("seqc", 32'hbfc00010);

        // cancel in flight: branch one cycle after addr_ok, data 3 cycles after the branch
        instruction_ram_address_ok = 1'b1;
        tick();
        instruction_ram_address_ok = 1'b0;
        id_branch_taken  = 1'b1;
        id_branch_target = 32'hbfc00100;
        tick();
        id_branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("cxl_wait_vld", 32'(to_if_valid), 32'd0);
            chk("cxl_wait_req", 32'(instruction_ram_request), 32'd0);
            tick();
        end
        instruction_ram_data_ok   = 1'b1;
        instruction_ram_read_data = 32'hdeadbeef;
        #1;
        chk("cxl_drop_vld", 32'(to_if_valid), 32'd0);
        tick();
        instruction_ram_data_ok = 1'b0;
        #1;
        chk("cxl_after_vld", 32'(to_if_valid), 32'd0);
        chk("cxl_next_req", 32'(instruction_ram_request), 32'd1);
        chk("cxl_next_addr", instruction_ram_address, 32'hbfc00100);

        // all three redirects with data_ok in the same cycle: exception wins
        instruction_ram_address_ok = 1'b1;
        tick();
        instruction_ram_address_ok = 1'b0;
        instruction_ram_data_ok    = 1'b1;
        instruction_ram_read_data  = 32'h55555555;
        wb_exception_valid         = 1'b1;
        wb_eret_flush              = 1'b1;
        cp0_epc                    = 32'h80001000;
        id_branch_taken            = 1'b1;
        id_branch_target           = 32'h12345678;
        #1;
        chk("sim_vld", 32'(to_if_valid), 32'd0);
        tick();
        instruction_ram_data_ok = 1'b0;
        wb_exception_valid      = 1'b0;
        wb_eret_flush           = 1'b0;
        id_branch_taken         = 1'b0;
        #1;
        chk("sim_vld_after", 32'(to_if_valid), 32'd0);
        chk("sim_req", 32'(instruction_ram_request), 32'd1);
        chk("sim_addr", instruction_ram_address, 32'hbfc00380);

        // misaligned eret target: no request, pair with zero word next cycle
        wb_eret_flush = 1'b1;
        cp0_epc       = 32'h80000002;
        tick();
        wb_eret_flush = 1'b0;
        #1;
        chk("mis_req", 32'(instruction_ram_request), 32'd0);
        chk("mis_vld0", 32'(to_if_valid), 32'd0);
        tick();
        #1;
        chk("mis_vld", 32'(to_if_valid), 32'd1);
        chk("mis_pc", to_if_program_count, 32'h80000002);
        chk("mis_inst", to_if_instruction, 32'd0);
        chk("mis_req_hold", 32'(instruction_ram_request), 32'd0);

        // branch while holding: pair dropped even with allow_in high
        if_allow_in      = 1'b1;
        id_branch_taken  = 1'b1;
        id_branch_target = 32'hbfc00200;
        #1;
        chk("hold_redir_vld", 32'(to_if_valid), 32'd0);
        tick();
        if_allow_in     = 1'b0;
        id_branch_taken = 1'b0;
        #1;
        chk("hold_redir_req", 32'(instruction_ram_request), 32'd1);
        chk("hold_redir_addr", instruction_ram_address, 32'hbfc00200);

        // addr_ok stalled 4 cycles, branch in the second: address switches, no cancel
        tick();
        #1;
        chk("stall_addr0", instruction_ram_address, 32'hbfc00200);
        id_branch_taken  = 1'b1;
        id_branch_target = 32'hbfc00300;
        tick();
        id_branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_req", 32'(instruction_ram_request), 32'd1);
            chk("stall_addr", instruction_ram_address, 32'hbfc00300);
            tick();
        end
        fetch("stall", 32'hbfc00300, 32'h66666666);
        transfer("stall", 32'hbfc00304);

        // pc+4 wraps at the top of the address space
        wb_eret_flush = 1'b1;
        cp0_epc       = 32'hfffffffc;
        tick();
        wb_eret_flush = 1'b0;
        fetch("wrap", 32'hfffffffc, 32'h77777777);
        transfer("wrap", 32'h00000000);

        // reset mid-transaction abandons the outstanding fetch
        instruction_ram_address_ok = 1'b1;
        tick();
        instruction_ram_address_ok = 1'b0;
        reset = 1'b0;
        tick();
        #1;
        chk("rst2_req", 32'(instruction_ram_request), 32'd0);
        chk("rst2_vld", 32'(to_if_valid), 32'd0);
        reset = 1'b1;
        fetch("rst2", 32'hbfc00000, 32'h88888888);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
